// File: rtl/sdpram_fifo_ctrl_pkg.sv
// Shared sizing helpers for the simple dual-port RAM FIFO controller.
//  addr_w   : RAM / buffer pointer width for a given depth (at least 1 bit)
//  cnt_w    : occupancy counter width able to hold 0..depth
//  strb_w   : write-enable width (per-byte strobes or a single enable)
//  ptr_wrap : next pointer value with explicit wrap at depth-1, so depth
//             need not be a power of two
package sdpram_fifo_ctrl_pkg;

  function automatic int unsigned addr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned strb_w(input int unsigned data_width,
                                         input int unsigned byte_write);
    return (byte_write != 0) ? data_width / 8 : 1;
  endfunction

  function automatic int unsigned ptr_wrap(input int unsigned ptr, input int unsigned depth);
    return (ptr >= depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/sdpram_fifo_ctrl_if.sv
// RAM-side bus of the simple dual-port RAM.
//  Port A (write): addra, wena, dina
//  Port B (read) : addrb, renb -> doutb, dvalb (dvalb marks returning read data)
//  sdp_m : controller side, drives addresses/enables/write data
//  sdp_s : RAM side, returns read data
interface sdpram_fifo_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = 1024,
  parameter int unsigned BYTE_WRITE = 0
);
  import sdpram_fifo_ctrl_pkg::*;

  localparam int unsigned ADDR_WIDTH = addr_w(MEM_DEPTH);
  localparam int unsigned STRB_WIDTH = strb_w(DATA_WIDTH, BYTE_WRITE);

  logic [ADDR_WIDTH-1:0] addra;
  logic [STRB_WIDTH-1:0] wena;
  logic [DATA_WIDTH-1:0] dina;
  logic [ADDR_WIDTH-1:0] addrb;
  logic                  renb;
  logic [DATA_WIDTH-1:0] doutb;
  logic                  dvalb;

  modport sdp_m (
    output addra, wena, dina, addrb, renb,
    input  doutb, dvalb
  );

  modport sdp_s (
    input  addra, wena, dina, addrb, renb,
    output doutb, dvalb
  );

endinterface

// File: rtl/sdpram_fifo_ctrl_obuf.sv
// Small register FIFO holding words read ahead from the RAM.
//  clk, rst : clock, synchronous active-high reset (clears occupancy/pointers)
//  wr_en/din: write a word; the caller's read credit guarantees space
//  rd_en    : pop the head word; dout is the current head
//  occ      : number of words held
//  empty    : occ == 0
// Write and read may happen in the same cycle at any occupancy.
module sdpram_fifo_ctrl_obuf
  import sdpram_fifo_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [DATA_WIDTH-1:0]        din,
  input  logic                         rd_en,
  output logic [DATA_WIDTH-1:0]        dout,
  output logic [cnt_w(DEPTH)-1:0]      occ,
  output logic                         empty
);

  localparam int unsigned PTR_WIDTH = addr_w(DEPTH);
  localparam int unsigned OCC_WIDTH = cnt_w(DEPTH);
  localparam logic [OCC_WIDTH-1:0] OCC_MAX = OCC_WIDTH'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr_q, rd_ptr_q;
  logic [OCC_WIDTH-1:0]  occ_q;
  logic                  do_wr, do_rd;

  always_comb begin
    do_rd = rd_en && (occ_q != '0);
    // A pop frees the slot this cycle, so a full buffer may still take a write.
    do_wr = wr_en && ((occ_q != OCC_MAX) || do_rd);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= PTR_WIDTH'(ptr_wrap(32'(wr_ptr_q), DEPTH));
      if (do_rd) rd_ptr_q <= PTR_WIDTH'(ptr_wrap(32'(rd_ptr_q), DEPTH));
      if (do_wr && !do_rd) begin
        occ_q <= occ_q + OCC_WIDTH'(1);
      end else if (!do_wr && do_rd) begin
        occ_q <= occ_q - OCC_WIDTH'(1);
      end
    end
  end

  // Data storage needs no reset; occupancy decides what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign occ   = occ_q;
  assign empty = (occ_q == '0);

endmodule

// File: rtl/sdpram_fifo_ctrl.sv
// Synchronous FIFO built on a simple dual-port RAM.
//  clk, rst                 : clock, synchronous active-high reset
//  s_data/s_valid/s_ready   : write stream (s_ready registered, = !full)
//  m_data/m_valid/m_ready   : read stream, served from a read-ahead buffer
//  count/full/empty         : words held in RAM + in flight + buffer
//  err                      : sticky, read data returned with no read outstanding
//  sdp                      : RAM bus (port A writes, port B reads)
// Reads are issued on credit: RAM words are fetched only while the reads in
// flight plus buffered words leave room in the buffer, so returning data is
// always accepted. RAM read latency is tracked purely through dvalb.
module sdpram_fifo_ctrl
  import sdpram_fifo_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = 1024,
  parameter int unsigned BYTE_WRITE = 0,
  parameter int unsigned OBUF_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic [DATA_WIDTH-1:0]         m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [cnt_w(MEM_DEPTH)-1:0]   count,
  output logic                          full,
  output logic                          empty,
  output logic                          err,
  sdpram_fifo_ctrl_if.sdp_m             sdp
);

  localparam int unsigned ADDR_WIDTH = addr_w(MEM_DEPTH);
  localparam int unsigned STRB_WIDTH = strb_w(DATA_WIDTH, BYTE_WRITE);
  localparam int unsigned CNT_WIDTH  = cnt_w(MEM_DEPTH);
  localparam int unsigned OCC_WIDTH  = cnt_w(OBUF_DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = CNT_WIDTH'(MEM_DEPTH);
  localparam logic [OCC_WIDTH:0]   CREDIT_MAX = (OCC_WIDTH + 1)'(OBUF_DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]  ram_cnt_q, ram_cnt_d, count_q, count_d;
  logic [OCC_WIDTH-1:0]  inflight_q, inflight_d, obuf_occ;
  logic [OCC_WIDTH:0]    credit_used;
  logic                  s_ready_q, full_q, empty_q, err_q, err_d;
  logic                  push, pop, issue, accept, stray;
  logic                  obuf_empty;

  always_comb begin
    // s_ready_q may still be high during the reset cycle; keep the RAM quiet.
    push        = s_valid && s_ready_q && !rst;
    pop         = m_valid && m_ready;
    credit_used = {1'b0, inflight_q} + {1'b0, obuf_occ};
    // Registered terms only, so renb/addrb have no path from the stream inputs.
    issue       = !rst && (ram_cnt_q != '0) && (credit_used < CREDIT_MAX);
    accept      = sdp.dvalb && (inflight_q != '0);
    stray       = sdp.dvalb && (inflight_q == '0);

    wr_ptr_d = push  ? ADDR_WIDTH'(ptr_wrap(32'(wr_ptr_q), MEM_DEPTH)) : wr_ptr_q;
    rd_ptr_d = issue ? ADDR_WIDTH'(ptr_wrap(32'(rd_ptr_q), MEM_DEPTH)) : rd_ptr_q;

    ram_cnt_d = ram_cnt_q;
    if (push && !issue) begin
      ram_cnt_d = ram_cnt_q + CNT_WIDTH'(1);
    end else if (!push && issue) begin
      ram_cnt_d = ram_cnt_q - CNT_WIDTH'(1);
    end

    inflight_d = inflight_q;
    if (issue && !accept) begin
      inflight_d = inflight_q + OCC_WIDTH'(1);
    end else if (!issue && accept) begin
      inflight_d = inflight_q - OCC_WIDTH'(1);
    end

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_WIDTH'(1);
    end else if (!push && pop) begin
      count_d = count_q - CNT_WIDTH'(1);
    end

    err_d = err_q || stray;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      inflight_q <= '0;
      count_q    <= '0;
      s_ready_q  <= 1'b0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ram_cnt_q  <= ram_cnt_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      // At full a same-cycle pop cannot enable a push; ready rises next cycle.
      s_ready_q  <= (count_d != CNT_MAX);
      full_q     <= (count_d == CNT_MAX);
      empty_q    <= (count_d == '0);
      err_q      <= err_d;
    end
  end

  sdpram_fifo_ctrl_obuf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (OBUF_DEPTH)
  ) u_obuf (
    .clk   (clk),
    .rst   (rst),
    .wr_en (accept),
    .din   (sdp.doutb),
    .rd_en (pop),
    .dout  (m_data),
    .occ   (obuf_occ),
    .empty (obuf_empty)
  );

  assign m_valid   = !obuf_empty;
  assign s_ready   = s_ready_q;
  assign count     = count_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign err       = err_q;

  assign sdp.addra = wr_ptr_q;
  assign sdp.wena  = {STRB_WIDTH{push}};
  assign sdp.dina  = s_data;
  assign sdp.addrb = rd_ptr_q;
  assign sdp.renb  = issue;

endmodule

// File: tb/tb_sdpram_fifo_ctrl.sv
// Bench for sdpram_fifo_ctrl: a RAM model with adjustable read latency, a
// queue-based reference of the FIFO contents checked every cycle, a directed
// vector table for first-word latency, and hand sequences for the corners.
module tb_sdpram_fifo_ctrl;
  import sdpram_fifo_ctrl_pkg::*;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 5;
  localparam int unsigned OBUF  = 2;
  localparam int unsigned CW    = cnt_w(DEPTH);
  localparam int unsigned AW    = addr_w(DEPTH);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [CW-1:0] count;
  logic          full, empty, err;

  always #5 clk = ~clk;

  sdpram_fifo_ctrl_if #(.DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .BYTE_WRITE(0)) sdp ();

  sdpram_fifo_ctrl #(
    .DATA_WIDTH (DW),
    .MEM_DEPTH  (DEPTH),
    .BYTE_WRITE (0),
    .OBUF_DEPTH (OBUF)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .count   (count),
    .full    (full),
    .empty   (empty),
    .err     (err),
    .sdp     (sdp)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- RAM model: read data returns lat cycles after renb ----------------
  typedef struct {
    int unsigned   due;
    logic [DW-1:0] data;
  } rd_t;

  rd_t           rq[$];
  int unsigned   cyc = 0;
  int unsigned   lat = 1;
  logic [DW-1:0] mem [DEPTH];
  logic          dvalb_r = 1'b0;
  logic [DW-1:0] doutb_r = '0;

  assign sdp.dvalb = dvalb_r;
  assign sdp.doutb = doutb_r;

  always @(posedge clk) begin
    if (sdp.renb) rq.push_back('{due: cyc + lat, data: mem[sdp.addrb]});
    if (|sdp.wena) mem[sdp.addra] <= sdp.dina;
    if (rq.size() != 0 && rq[0].due == cyc + 1) begin
      dvalb_r <= 1'b1;
      doutb_r <= rq[0].data;
      void'(rq.pop_front());
    end else begin
      dvalb_r <= 1'b0;
    end
    cyc <= cyc + 1;
  end

  // ---------------- reference model, sampled on the falling edge ----------------
  logic [DW-1:0] exp_q[$];
  int unsigned   issued, delivered, popped, pushes, wr_idx, rd_idx, max_used;
  logic          exp_err;
  bit            after_rst;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        check("rst_renb", 64'(sdp.renb), 64'(0));
        check("rst_wena", 64'(sdp.wena), 64'(0));
        exp_q.delete();
        issued = 0; delivered = 0; popped = 0; pushes = 0;
        wr_idx = 0; rd_idx = 0; exp_err = 1'b0;
        after_rst = 1'b1;
      end else begin
        int unsigned occ, used;
        logic push_now;
        occ      = delivered - popped;
        used     = issued - popped;
        push_now = s_valid && s_ready;
        if (used > max_used) max_used = used;

        check("count", 64'(count), 64'(exp_q.size()));
        check("empty", 64'(empty), 64'(exp_q.size() == 0));
        check("full", 64'(full), 64'(exp_q.size() == DEPTH));
        if (!after_rst) check("s_ready", 64'(s_ready), 64'(exp_q.size() != DEPTH));
        check("err", 64'(err), 64'(exp_err));
        check("m_valid", 64'(m_valid), 64'(occ != 0));
        if (m_valid && exp_q.size() != 0) check("m_data", 64'(m_data), 64'(exp_q[0]));
        check("credit", 64'(used <= OBUF), 64'(1));
        check("wena", 64'(sdp.wena), 64'(push_now));
        if (push_now) begin
          check("addra", 64'(sdp.addra), 64'(wr_idx));
          check("dina", 64'(sdp.dina), 64'(s_data));
        end
        if (sdp.renb) begin
          check("addrb", 64'(sdp.addrb), 64'(rd_idx));
          check("renb_has_word", 64'(pushes > issued), 64'(1));
        end
        if (sdp.dvalb) begin
          if (issued == delivered) begin
            exp_err = 1'b1;
          end else begin
            if (delivered - popped < exp_q.size())
              check("doutb", 64'(sdp.doutb), 64'(exp_q[delivered - popped]));
            delivered++;
          end
        end

        if (push_now) begin
          exp_q.push_back(s_data);
          pushes++;
          wr_idx = (wr_idx + 1) % DEPTH;
        end
        if (m_valid && m_ready && exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          popped++;
        end
        if (sdp.renb) begin
          issued++;
          rd_idx = (rd_idx + 1) % DEPTH;
        end
        after_rst = 1'b0;
      end
    end
  end

  // ---------------- directed vectors ----------------
  typedef struct {
    logic          sv;
    logic [DW-1:0] sd;
    logic          mr;
    logic          renb;
    logic [AW-1:0] addrb;
    logic          mv;
    logic [DW-1:0] md;
    logic [CW-1:0] cnt;
    logic          emp;
  } vec_t;

  vec_t vt[5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    bit done;
    done = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && count == '0 && issued == delivered) done = 1'b1;
      step();
      if (done) break;
    end
    check(name, 64'(done), 64'(1));
    m_ready = 1'b0;
  endtask

  initial begin
    int unsigned issued0, pushes0, n, guard;
    bit acc;

    vt[0] = '{1'b1, 32'hA5A5A5A5, 1'b1, 1'b0, AW'(0), 1'b0, 32'h0, CW'(0), 1'b1};
    vt[1] = '{1'b0, 32'h0,        1'b1, 1'b1, AW'(0), 1'b0, 32'h0, CW'(1), 1'b0};
    vt[2] = '{1'b0, 32'h0,        1'b1, 1'b0, AW'(0), 1'b0, 32'h0, CW'(1), 1'b0};
    vt[3] = '{1'b0, 32'h0,        1'b1, 1'b0, AW'(0), 1'b1, 32'hA5A5A5A5, CW'(1), 1'b0};
    vt[4] = '{1'b0, 32'h0,        1'b1, 1'b0, AW'(0), 1'b0, 32'h0, CW'(0), 1'b1};

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_ready", 64'(s_ready), 64'(0));
    check("rst_m_valid", 64'(m_valid), 64'(0));
    check("rst_count", 64'(count), 64'(0));
    check("rst_empty", 64'(empty), 64'(1));
    check("rst_full", 64'(full), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    step();
    rst = 1'b0;
    step();

    // First-word latency with L=1
    lat = 1;
    for (int i = 0; i < 5; i++) begin
      s_valid = vt[i].sv;
      s_data  = vt[i].sd;
      m_ready = vt[i].mr;
      @(negedge clk);
      if (i == 0) check("t1_s_ready", 64'(s_ready), 64'(1));
      check($sformatf("t1_renb[%0d]", i), 64'(sdp.renb), 64'(vt[i].renb));
      if (vt[i].renb) check($sformatf("t1_addrb[%0d]", i), 64'(sdp.addrb), 64'(vt[i].addrb));
      check($sformatf("t1_m_valid[%0d]", i), 64'(m_valid), 64'(vt[i].mv));
      if (vt[i].mv) check($sformatf("t1_m_data[%0d]", i), 64'(m_data), 64'(vt[i].md));
      check($sformatf("t1_count[%0d]", i), 64'(count), 64'(vt[i].cnt));
      check($sformatf("t1_empty[%0d]", i), 64'(empty), 64'(vt[i].emp));
      step();
    end
    s_valid = 1'b0;
    m_ready = 1'b0;

    // Fill to full with the output stalled
    issued0 = issued;
    n = 0;
    guard = 0;
    while (n < DEPTH && guard < 100) begin
      s_valid = 1'b1;
      s_data  = 32'h100 + n;
      @(negedge clk);
      acc = s_ready;
      step();
      if (acc) n++;
      guard++;
    end
    s_valid = 1'b0;
    check("t2_fill_done", 64'(n), 64'(DEPTH));
    repeat (6) step();
    @(negedge clk);
    check("t2_full", 64'(full), 64'(1));
    check("t2_s_ready", 64'(s_ready), 64'(0));
    check("t2_count", 64'(count), 64'(DEPTH));
    check("t2_reads_issued", 64'(issued - issued0), 64'(OBUF));
    step();

    // Full: push attempt and pop in the same cycle
    s_valid = 1'b1;
    s_data  = 32'hBEEF;
    m_ready = 1'b1;
    @(negedge clk);
    check("t4_s_ready_low", 64'(s_ready), 64'(0));
    check("t4_m_valid", 64'(m_valid), 64'(1));
    step();
    m_ready = 1'b0;
    @(negedge clk);
    check("t4_count_after_pop", 64'(count), 64'(DEPTH - 1));
    check("t4_s_ready_back", 64'(s_ready), 64'(1));
    step();
    s_valid = 1'b0;
    @(negedge clk);
    check("t4_count_refill", 64'(count), 64'(DEPTH));
    check("t4_full_again", 64'(full), 64'(1));
    step();
    drain("t2_drain");

    // Random traffic, wrapping addresses, random latency
    lat = 1 + ($urandom % 3);
    pushes0 = pushes;
    guard = 0;
    while (pushes - pushes0 < 20 && guard < 400) begin
      s_valid = 1'($urandom % 2);
      s_data  = $urandom;
      m_ready = 1'($urandom % 2);
      step();
      guard++;
    end
    check("t3_pushed", 64'(pushes - pushes0 >= 20), 64'(1));
    drain("t3_drain");
    @(negedge clk);
    check("t3_no_err", 64'(err), 64'(0));
    step();

    // Long latency, continuous traffic
    lat = 3;
    max_used = 0;
    pushes0 = pushes;
    s_valid = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      s_data = $urandom;
      step();
    end
    s_valid = 1'b0;
    drain("t5_drain");
    check("t5_max_credit", 64'(max_used <= OBUF), 64'(1));
    check("t5_pushed", 64'(pushes - pushes0 > 10), 64'(1));

    // Reset with two reads in flight
    lat = 3;
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_data  = 32'h600 + i;
      step();
    end
    s_valid = 1'b0;
    check("t6_inflight", 64'(issued - delivered), 64'(2));
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("t6_s_ready", 64'(s_ready), 64'(0));
    check("t6_m_valid", 64'(m_valid), 64'(0));
    check("t6_count", 64'(count), 64'(0));
    check("t6_empty", 64'(empty), 64'(1));
    check("t6_full", 64'(full), 64'(0));
    check("t6_err_clear", 64'(err), 64'(0));
    check("t6_late_dvalb", 64'(sdp.dvalb), 64'(1));
    step();
    @(negedge clk);
    check("t6_err_set", 64'(err), 64'(1));
    check("t6_m_valid_after", 64'(m_valid), 64'(0));
    step();
    repeat (3) step();
    @(negedge clk);
    check("t6_err_sticky", 64'(err), 64'(1));
    check("t6_m_valid_stays", 64'(m_valid), 64'(0));
    check("t6_count_stays", 64'(count), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
